// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM states,
// opcodes, funct3 codes and the datapath mux/ALU encodings.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic is_branch_f3(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt);
        logic taken;
        case (f3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R-type, I-type and branch instructions, plus a
// flag for funct3 values the controller does not implement.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] ALUControl,
    output logic       bad_funct
);

    // Only funct7[5] selects sub; the remaining bits carry no meaning here.
    logic w_unused_funct7;
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ALUControl = ALU_ADD;
        bad_funct  = 1'b0;
        case (opcode)
            OP_RTYPE, OP_ITYPE: begin
                case (funct3)
                    F3_ADD:  ALUControl = (opcode == OP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
                    F3_AND:  ALUControl = ALU_AND;
                    F3_OR:   ALUControl = ALU_OR;
                    F3_SLT:  ALUControl = ALU_SLT;
                    F3_XOR:  ALUControl = ALU_XOR;
                    default: bad_funct  = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                ALUControl = ALU_SUB;
                bad_funct  = !is_branch_f3(funct3);
            end
            default: begin
                ALUControl = ALU_ADD;
                bad_funct  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style main FSM of a multicycle RISC-V datapath; outputs decode from
// the state register, with only PCWrite in BRANCH depending on ALU flags.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] w_alu_decoded;
    logic       w_bad_funct;
    logic       w_op_legal;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    alu_decoder u_alu_decoder (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUControl (w_alu_decoded),
        .bad_funct  (w_bad_funct)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: w_op_legal = 1'b1;
            default:                            w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_B;
        ALUControl   = ALU_ADD;
        ImmSrc       = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut while decoding.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_BRANCH) begin
                    ImmSrc = IMM_B;
                end else if (opcode == OP_JAL) begin
                    ImmSrc = IMM_J;
                end
                if (!w_op_legal || w_bad_funct) begin
                    w_illegal    = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                        OP_RTYPE:          w_next_state = S_EXEC_R;
                        OP_ITYPE:          w_next_state = S_EXEC_I;
                        OP_BRANCH:         w_next_state = S_BRANCH;
                        OP_JAL:            w_next_state = S_JAL;
                        OP_JALR:           w_next_state = S_JALR;
                        OP_LUI:            w_next_state = S_LUI;
                        default:           w_next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_IMM;
                ImmSrc       = (opcode == OP_LOAD) ? IMM_I : IMM_S;
                w_next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                w_mem_write  = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA      = SRCA_A;
                ALUControl   = w_alu_decoded;
                w_next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_IMM;
                ALUControl   = w_alu_decoded;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = SRCA_A;
                ALUControl   = ALU_SUB;
                w_pc_write   = branch_taken(funct3, zero, lt);
            end
            S_JAL: begin
                w_pc_write   = 1'b1;
                w_next_state = S_LINK;
            end
            S_JALR: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_IMM;
                ResultSrc    = RES_ALURESULT;
                w_pc_write   = 1'b1;
                w_next_state = S_LINK;
            end
            S_LINK: begin
                // rd <= old PC + 4, after the PC has already been redirected.
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_reg_write  = 1'b1;
            end
            S_LUI: begin
                ImmSrc       = IMM_U;
                ResultSrc    = RES_IMMEXT;
                w_reg_write  = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Write enables are masked by reset directly so they drop without a clock.
    assign PCWrite  = w_pc_write  & rst;
    assign IRWrite  = w_ir_write  & rst;
    assign MemWrite = w_mem_write & rst;
    assign RegWrite = w_reg_write & rst;
    assign illegal  = w_illegal   & rst;
    assign state    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle expected
// control vectors, a monitor pops and compares one each sample point.
module tb_multicycle_controller;
    import riscv_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       lt;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] state;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .lt         (lt),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [21:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    event     sample_now;

    // Vector layout: state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    // ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal.
    function automatic logic [21:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sbv, input logic [2:0] alu,
                                       input logic [2:0] imm, input logic ill);
        return {st, pcw, adr, mw, irw, rw, rs, sa, sbv, alu, imm, ill};
    endfunction

    function automatic logic [21:0] fetch_v();
        return ev(4'(S_FETCH), 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    endfunction

    function automatic logic [21:0] reset_v();
        return ev(4'(S_FETCH), 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    endfunction

    function automatic logic [21:0] decode_v(input logic [2:0] imm, input logic ill);
        return ev(4'(S_DECODE), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill);
    endfunction

    function automatic void expect_cyc(input string nm, input logic [21:0] v);
        sb_item_t it;
        it.name = nm;
        it.exp  = v;
        sb.push_back(it);
    endfunction

    // Monitor: one comparison per clock low phase, or on demand for async checks.
    initial begin
        sb_item_t    it;
        logic [21:0] act;
        forever begin
            @(negedge clk or sample_now);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};
                n_checks++;
                if (act !== it.exp) begin
                    $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z, input logic l);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
        lt     = l;
        $display("instr %-10s op=%b f3=%b f7=%b zero=%b lt=%b", nm, op, f3, f7, z, l);
        expect_cyc({nm, ".fetch"}, fetch_v());
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string nm, input logic is_r, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [2:0] alu);
        issue(nm, is_r ? OP_RTYPE : OP_ITYPE, f3, f7, 0, 0);
        expect_cyc({nm, ".decode"}, decode_v(3'b000, 0));
        if (is_r) begin
            expect_cyc({nm, ".exec"}, ev(4'(S_EXEC_R), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 0));
        end else begin
            expect_cyc({nm, ".exec"}, ev(4'(S_EXEC_I), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 0));
        end
        expect_cyc({nm, ".wb"}, ev(4'(S_ALUWB), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        cycles(4);
    endtask

    task automatic branch(input string nm, input logic [2:0] f3, input logic z,
                          input logic l, input logic taken);
        issue(nm, OP_BRANCH, f3, 7'b0, z, l);
        expect_cyc({nm, ".decode"}, decode_v(3'b010, 0));
        expect_cyc({nm, ".branch"}, ev(4'(S_BRANCH), taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        cycles(3);
    endtask

    task automatic bad(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [2:0] imm);
        issue(nm, op, f3, 7'b0, 0, 0);
        expect_cyc({nm, ".decode"}, decode_v(imm, 1));
        cycles(2);
    endtask

    initial begin
        rst    = 1'b0;
        opcode = 7'b0;
        funct3 = 3'b0;
        funct7 = 7'b0;
        zero   = 1'b0;
        lt     = 1'b0;
        #1;
        expect_cyc("reset.hold", reset_v());
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        alu_op("add",  1, 3'b000, 7'b0000000, 3'b000);
        alu_op("sub",  1, 3'b000, 7'b0100000, 3'b001);
        alu_op("and",  1, 3'b111, 7'b0000000, 3'b010);
        alu_op("or",   1, 3'b110, 7'b0000000, 3'b011);
        alu_op("slt",  1, 3'b010, 7'b0000000, 3'b100);
        alu_op("xor",  1, 3'b100, 7'b0000000, 3'b101);
        alu_op("addi", 0, 3'b000, 7'b0100000, 3'b000);
        alu_op("xori", 0, 3'b100, 7'b0000000, 3'b101);
        alu_op("slti", 0, 3'b010, 7'b0000000, 3'b100);

        issue("lw", OP_LOAD, 3'b010, 7'b0, 0, 0);
        expect_cyc("lw.decode",  decode_v(3'b000, 0));
        expect_cyc("lw.memadr",  ev(4'(S_MEMADR),  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        expect_cyc("lw.memread", ev(4'(S_MEMREAD), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        expect_cyc("lw.memwb",   ev(4'(S_MEMWB),   0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        cycles(5);

        issue("sw", OP_STORE, 3'b010, 7'b0, 0, 0);
        expect_cyc("sw.decode",   decode_v(3'b000, 0));
        expect_cyc("sw.memadr",   ev(4'(S_MEMADR),   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
        expect_cyc("sw.memwrite", ev(4'(S_MEMWRITE), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        cycles(4);

        branch("beq.z1",  3'b000, 1, 0, 1);
        branch("beq.z0",  3'b000, 0, 0, 0);
        branch("bne.z0",  3'b001, 0, 0, 1);
        branch("bne.z1",  3'b001, 1, 0, 0);
        branch("blt.lt1", 3'b100, 0, 1, 1);
        branch("blt.lt0", 3'b100, 0, 0, 0);
        branch("bge.lt0", 3'b101, 0, 0, 1);
        branch("bge.lt1", 3'b101, 0, 1, 0);

        issue("jal", OP_JAL, 3'b000, 7'b0, 0, 0);
        expect_cyc("jal.decode", decode_v(3'b011, 0));
        expect_cyc("jal.jal",    ev(4'(S_JAL),  1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        expect_cyc("jal.link",   ev(4'(S_LINK), 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        cycles(4);

        issue("jalr", OP_JALR, 3'b000, 7'b0, 0, 0);
        expect_cyc("jalr.decode", decode_v(3'b000, 0));
        expect_cyc("jalr.jalr",   ev(4'(S_JALR), 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        expect_cyc("jalr.link",   ev(4'(S_LINK), 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        cycles(4);

        issue("lui", OP_LUI, 3'b000, 7'b0, 0, 0);
        expect_cyc("lui.decode", decode_v(3'b000, 0));
        expect_cyc("lui.lui",    ev(4'(S_LUI), 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0));
        cycles(3);

        bad("ill.op7f",  7'b1111111, 3'b000, 3'b000);
        bad("ill.rf3",   OP_RTYPE,   3'b001, 3'b000);
        bad("ill.if3",   OP_ITYPE,   3'b011, 3'b000);
        bad("ill.bf3",   OP_BRANCH,  3'b010, 3'b010);
        bad("ill.op00",  7'b0000000, 3'b000, 3'b000);

        // Reset asserted asynchronously while MEMWRITE is active.
        issue("sw.rst", OP_STORE, 3'b010, 7'b0, 0, 0);
        expect_cyc("sw.rst.decode",   decode_v(3'b000, 0));
        expect_cyc("sw.rst.memadr",   ev(4'(S_MEMADR),   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
        expect_cyc("sw.rst.memwrite", ev(4'(S_MEMWRITE), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        expect_cyc("sw.rst.async", reset_v());
        -> sample_now;
        #1;
        expect_cyc("sw.rst.held", reset_v());
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        alu_op("add.post", 1, 3'b000, 7'b0000000, 3'b000);
        issue("end", 7'b0, 3'b000, 7'b0, 0, 0);
        cycles(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
